// File: rtl/sr_crypto_seq.sv
// sr_crypto_seq: multi-cycle sequencer for scalar-crypto instructions.
// It stalls the core, latches the operands and dispatches them to one of
// N_UNITS engines over a valid/ready handshake. It then captures the result
// and writes it back through a dedicated register-file write port. A
// timeout path and an illegal-unit path both write 0 and raise a sticky err.
module sr_crypto_seq #(
    parameter int DATA_W  = 32,
    parameter int MODE_W  = 21,
    parameter int N_UNITS = 2,
    parameter int SEL_W   = (N_UNITS > 1) ? $clog2(N_UNITS) : 1,
    parameter int TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        crypt_instr,
    input  logic [SEL_W-1:0]            unit_sel,
    input  logic [MODE_W-1:0]           cryptoMode,
    input  logic [DATA_W-1:0]           rs1_data,
    input  logic [DATA_W-1:0]           rs2_data,
    input  logic [4:0]                  rd_addr,
    output logic                        hold,
    output logic                        ctrls_select,
    output logic                        rfWe,
    output logic [4:0]                  rfWa,
    output logic [DATA_W-1:0]           rfWd,
    output logic [N_UNITS-1:0]          cry_i_valid,
    input  logic [N_UNITS-1:0]          cry_i_ready,
    output logic [MODE_W-1:0]           cry_mode,
    output logic [DATA_W-1:0]           cry_a,
    output logic [DATA_W-1:0]           cry_b,
    input  logic [N_UNITS-1:0]          cry_o_valid,
    input  logic [N_UNITS*DATA_W-1:0]   cry_o_data,
    output logic                        err
);

    // Select space is a power of two; unused slots read as idle engines so
    // the selected-unit lookups never index outside a vector.
    localparam int PAD_N = 2 ** SEL_W;
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [SEL_W:0]   N_UNITS_L = (SEL_W + 1)'(N_UNITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WB
    } state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [SEL_W-1:0]    sel_reg;
    logic [MODE_W-1:0]   mode_reg;
    logic [DATA_W-1:0]   a_reg;
    logic [DATA_W-1:0]   b_reg;
    logic [4:0]          rd_reg;
    logic [DATA_W-1:0]   res_reg;
    logic [N_UNITS-1:0]  i_valid_reg;
    logic                rfwe_reg;
    logic                ctrls_reg;
    logic                err_reg;

    logic [PAD_N-1:0]    ready_pad;
    logic [PAD_N-1:0]    ovalid_pad;
    logic [DATA_W-1:0]   data_pad [PAD_N];
    logic [N_UNITS-1:0]  sel_onehot;
    logic                unit_legal;
    logic                timed_out;

    genvar gi;

    // Map the engine buses onto a full power-of-two select space.
    generate
        for (gi = 0; gi < PAD_N; gi++) begin : g_pad
            if (gi < N_UNITS) begin : g_unit
                assign ready_pad[gi]  = cry_i_ready[gi];
                assign ovalid_pad[gi] = cry_o_valid[gi];
                assign data_pad[gi]   = cry_o_data[gi*DATA_W +: DATA_W];
            end else begin : g_empty
                assign ready_pad[gi]  = 1'b0;
                assign ovalid_pad[gi] = 1'b0;
                assign data_pad[gi]   = '0;
            end
        end

        // Decode the incoming select into the one-hot request pattern.
        for (gi = 0; gi < N_UNITS; gi++) begin : g_dec
            assign sel_onehot[gi] = (unit_sel == SEL_W'(gi));
        end
    endgenerate

    assign unit_legal = ({1'b0, unit_sel} < N_UNITS_L);
    assign timed_out  = (cnt_reg == CNT_LAST);

    // Sequencer FSM: latches the instruction, runs the handshake, owns write-back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            sel_reg     <= '0;
            mode_reg    <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            rd_reg      <= '0;
            res_reg     <= '0;
            i_valid_reg <= '0;
            rfwe_reg    <= 1'b0;
            ctrls_reg   <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (crypt_instr) begin
                        sel_reg  <= unit_sel;
                        mode_reg <= cryptoMode;
                        a_reg    <= rs1_data;
                        b_reg    <= rs2_data;
                        rd_reg   <= rd_addr;
                        cnt_reg  <= '0;
                        if (unit_legal) begin
                            i_valid_reg <= sel_onehot;
                            state_reg   <= ST_ISSUE;
                        end else begin
                            // No engine to ask: write back zero and flag it.
                            res_reg   <= '0;
                            err_reg   <= 1'b1;
                            ctrls_reg <= 1'b1;
                            rfwe_reg  <= (rd_addr != 5'd0);
                            state_reg <= ST_WB;
                        end
                    end
                end

                ST_ISSUE: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (timed_out) begin
                        i_valid_reg <= '0;
                        res_reg     <= '0;
                        err_reg     <= 1'b1;
                        ctrls_reg   <= 1'b1;
                        rfwe_reg    <= (rd_reg != 5'd0);
                        state_reg   <= ST_WB;
                    end else if (ready_pad[sel_reg]) begin
                        i_valid_reg <= '0;
                        state_reg   <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    // A result arriving on the last cycle still counts as completion.
                    if (ovalid_pad[sel_reg]) begin
                        res_reg   <= data_pad[sel_reg];
                        ctrls_reg <= 1'b1;
                        rfwe_reg  <= (rd_reg != 5'd0);
                        state_reg <= ST_WB;
                    end else if (timed_out) begin
                        res_reg   <= '0;
                        err_reg   <= 1'b1;
                        ctrls_reg <= 1'b1;
                        rfwe_reg  <= (rd_reg != 5'd0);
                        state_reg <= ST_WB;
                    end
                end

                ST_WB: begin
                    // One write-back cycle; a crypto flag seen here belongs
                    // to the old PC and is deliberately ignored.
                    ctrls_reg <= 1'b0;
                    rfwe_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    i_valid_reg <= '0;
                    ctrls_reg   <= 1'b0;
                    rfwe_reg    <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall is combinational so the detecting cycle itself is already held.
    always_comb begin
        hold = 1'b0;
        case (state_reg)
            ST_IDLE:  hold = crypt_instr;
            ST_ISSUE: hold = 1'b1;
            ST_WAIT:  hold = 1'b1;
            default:  hold = 1'b0;
        endcase
    end

    assign ctrls_select = ctrls_reg;
    assign rfWe         = rfwe_reg;
    assign rfWa         = rd_reg;
    assign rfWd         = res_reg;
    assign cry_i_valid  = i_valid_reg;
    assign cry_mode     = mode_reg;
    assign cry_a        = a_reg;
    assign cry_b        = b_reg;
    assign err          = err_reg;

endmodule

// File: tb/tb_sr_crypto_seq.sv
// Directed bench for sr_crypto_seq: a two-engine instance for the main
// handshake, timeout and reset scenarios, and a three-engine instance
// for the illegal-unit path.
module tb_sr_crypto_seq;

    logic clk;
    logic rst_n;

    int tests;
    int fails;

    // Two-unit instance
    logic        a_crypt;
    logic [0:0]  a_sel;
    logic [20:0] a_mode;
    logic [31:0] a_rs1, a_rs2;
    logic [4:0]  a_rd;
    logic        a_hold, a_csel, a_we;
    logic [4:0]  a_wa;
    logic [31:0] a_wd;
    logic [1:0]  a_ivalid, a_iready, a_ovalid;
    logic [20:0] a_cmode;
    logic [31:0] a_ca, a_cb;
    logic [63:0] a_odata;
    logic        a_err;

    // Three-unit instance
    logic        b_crypt;
    logic [1:0]  b_sel;
    logic [20:0] b_mode;
    logic [31:0] b_rs1, b_rs2;
    logic [4:0]  b_rd;
    logic        b_hold, b_csel, b_we;
    logic [4:0]  b_wa;
    logic [31:0] b_wd;
    logic [2:0]  b_ivalid, b_iready, b_ovalid;
    logic [20:0] b_cmode;
    logic [31:0] b_ca, b_cb;
    logic [95:0] b_odata;
    logic        b_err;

    sr_crypto_seq #(.N_UNITS(2), .TIMEOUT(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .crypt_instr(a_crypt), .unit_sel(a_sel),
        .cryptoMode(a_mode), .rs1_data(a_rs1), .rs2_data(a_rs2), .rd_addr(a_rd),
        .hold(a_hold), .ctrls_select(a_csel), .rfWe(a_we), .rfWa(a_wa), .rfWd(a_wd),
        .cry_i_valid(a_ivalid), .cry_i_ready(a_iready), .cry_mode(a_cmode),
        .cry_a(a_ca), .cry_b(a_cb), .cry_o_valid(a_ovalid), .cry_o_data(a_odata),
        .err(a_err)
    );

    sr_crypto_seq #(.N_UNITS(3), .TIMEOUT(64)) dut_b (
        .clk(clk), .rst_n(rst_n), .crypt_instr(b_crypt), .unit_sel(b_sel),
        .cryptoMode(b_mode), .rs1_data(b_rs1), .rs2_data(b_rs2), .rd_addr(b_rd),
        .hold(b_hold), .ctrls_select(b_csel), .rfWe(b_we), .rfWa(b_wa), .rfWd(b_wd),
        .cry_i_valid(b_ivalid), .cry_i_ready(b_iready), .cry_mode(b_cmode),
        .cry_a(b_ca), .cry_b(b_cb), .cry_o_valid(b_ovalid), .cry_o_data(b_odata),
        .err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        a_crypt = 0; a_sel = 0; a_mode = 0; a_rs1 = 0; a_rs2 = 0; a_rd = 0;
        a_iready = 0; a_ovalid = 0; a_odata = 0;
        b_crypt = 0; b_sel = 0; b_mode = 0; b_rs1 = 0; b_rs2 = 0; b_rd = 0;
        b_iready = 0; b_ovalid = 0; b_odata = 0;

        // ---------------- reset state ----------------
        tick; tick;
        check("rst_ivalid", a_ivalid, 2'b00);
        check("rst_we", a_we, 1'b0);
        check("rst_csel", a_csel, 1'b0);
        check("rst_err", a_err, 1'b0);
        check("rst_wd", a_wd, 32'h0);
        check("rst_hold_low", a_hold, 1'b0);
        a_crypt = 1'b1; #1;
        check("rst_hold_follow", a_hold, 1'b1);
        a_crypt = 1'b0;
        rst_n = 1'b1;
        tick;

        // ---------------- unit 0, minimum latency ----------------
        a_crypt = 1; a_sel = 0; a_rs1 = 32'h11; a_rs2 = 32'h22; a_rd = 5;
        a_mode = 21'h1A5A5; a_iready = 2'b11; #1;
        check("u0_T0_hold", a_hold, 1'b1);
        check("u0_T0_ivalid", a_ivalid, 2'b00);
        tick; a_crypt = 0; #1;
        check("u0_T1_hold", a_hold, 1'b1);
        check("u0_T1_ivalid", a_ivalid, 2'b01);
        check("u0_T1_a", a_ca, 32'h11);
        check("u0_T1_b", a_cb, 32'h22);
        check("u0_T1_mode", a_cmode, 21'h1A5A5);
        tick; a_ovalid = 2'b01; a_odata = {32'h0, 32'hDEADBEEF}; #1;
        check("u0_T2_hold", a_hold, 1'b1);
        check("u0_T2_ivalid", a_ivalid, 2'b00);
        tick; a_ovalid = 2'b00; #1;
        check("u0_T3_we", a_we, 1'b1);
        check("u0_T3_wa", a_wa, 5'd5);
        check("u0_T3_wd", a_wd, 32'hDEADBEEF);
        check("u0_T3_csel", a_csel, 1'b1);
        check("u0_T3_hold", a_hold, 1'b0);
        check("u0_T3_err", a_err, 1'b0);
        tick;
        check("u0_T4_we", a_we, 1'b0);
        check("u0_T4_csel", a_csel, 1'b0);

        // ---------------- unit 1, delayed ready and result ----------------
        a_crypt = 1; a_sel = 1; a_rs1 = 32'h33; a_rs2 = 32'h44; a_rd = 6; a_iready = 2'b00; #1;
        check("u1_T0_hold", a_hold, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            tick; a_crypt = 0; #1;
            check($sformatf("u1_T%0d_ivalid", i), a_ivalid, 2'b10);
        end
        tick; a_iready = 2'b10; #1;
        check("u1_T5_ivalid", a_ivalid, 2'b10);
        tick; a_iready = 2'b00; a_ovalid = 2'b01; a_odata = {32'hCAFEF00D, 32'h12345678}; #1;
        check("u1_T6_ivalid", a_ivalid, 2'b00);
        check("u1_T6_hold", a_hold, 1'b1);
        tick; a_ovalid = 2'b00; #1;
        check("u1_T7_hold", a_hold, 1'b1);
        tick; a_ovalid = 2'b10; #1;
        check("u1_T8_hold", a_hold, 1'b1);
        tick; a_ovalid = 2'b00; #1;
        check("u1_T9_we", a_we, 1'b1);
        check("u1_T9_wa", a_wa, 5'd6);
        check("u1_T9_wd", a_wd, 32'hCAFEF00D);
        check("u1_T9_err", a_err, 1'b0);
        tick;

        // ---------------- rd = 0 with a legal unit ----------------
        a_crypt = 1; a_sel = 0; a_rs1 = 32'h1; a_rd = 0; a_iready = 2'b01; #1;
        tick; a_crypt = 0; #1;
        tick; a_ovalid = 2'b01; a_odata = {32'h0, 32'h55}; #1;
        tick; a_ovalid = 2'b00; #1;
        check("rd0_we", a_we, 1'b0);
        check("rd0_csel", a_csel, 1'b1);
        check("rd0_wd", a_wd, 32'h55);
        tick;

        // ---------------- back-to-back instructions ----------------
        a_crypt = 1; a_sel = 0; a_rs1 = 32'hA1; a_rd = 3; a_iready = 2'b01; #1;
        tick;
        tick; a_ovalid = 2'b01; a_odata = {32'h0, 32'h111}; #1;
        tick; a_ovalid = 2'b00; a_rd = 4; a_rs1 = 32'hB2; #1;
        check("b2b_wb1_wa", a_wa, 5'd3);
        check("b2b_wb1_wd", a_wd, 32'h111);
        check("b2b_wb1_hold", a_hold, 1'b0);
        tick;
        check("b2b_det2_hold", a_hold, 1'b1);
        check("b2b_det2_ivalid", a_ivalid, 2'b00);
        tick; a_crypt = 0; #1;
        check("b2b_iss2_ivalid", a_ivalid, 2'b01);
        check("b2b_iss2_a", a_ca, 32'hB2);
        tick; a_ovalid = 2'b01; a_odata = {32'h0, 32'h222}; #1;
        tick; a_ovalid = 2'b00; #1;
        check("b2b_wb2_wa", a_wa, 5'd4);
        check("b2b_wb2_wd", a_wd, 32'h222);
        check("b2b_wb2_we", a_we, 1'b1);
        tick;

        // ---------------- timeout, unit 0 never responds ----------------
        a_crypt = 1; a_sel = 0; a_rd = 7; a_iready = 2'b00; #1;
        tick; a_crypt = 0; #1;
        check("to_T1_ivalid", a_ivalid, 2'b01);
        for (int i = 2; i <= 64; i++) begin
            tick;
            check($sformatf("to_T%0d_hold", i), a_hold, 1'b1);
        end
        check("to_T64_ivalid", a_ivalid, 2'b01);
        check("to_T64_err", a_err, 1'b0);
        tick;
        check("to_T65_we", a_we, 1'b1);
        check("to_T65_wa", a_wa, 5'd7);
        check("to_T65_wd", a_wd, 32'h0);
        check("to_T65_err", a_err, 1'b1);
        check("to_T65_ivalid", a_ivalid, 2'b00);
        check("to_T65_csel", a_csel, 1'b1);
        tick; tick;
        check("to_err_sticky", a_err, 1'b1);

        // ---------------- illegal unit on the three-unit instance ----------------
        b_crypt = 1; b_sel = 2'd3; b_rd = 9; b_rs1 = 32'h77; b_iready = 3'b111; #1;
        check("ill_T0_hold", b_hold, 1'b1);
        check("ill_T0_ivalid", b_ivalid, 3'b000);
        tick; b_crypt = 0; #1;
        check("ill_T1_we", b_we, 1'b1);
        check("ill_T1_wa", b_wa, 5'd9);
        check("ill_T1_wd", b_wd, 32'h0);
        check("ill_T1_err", b_err, 1'b1);
        check("ill_T1_ivalid", b_ivalid, 3'b000);
        check("ill_T1_hold", b_hold, 1'b0);
        tick;

        // ---------------- reset during WAIT ----------------
        a_crypt = 1; a_sel = 1; a_rs1 = 32'h99; a_rd = 8; a_iready = 2'b10; #1;
        tick; a_crypt = 0; #1;
        tick; #1;
        check("rw_wait_hold", a_hold, 1'b1);
        rst_n = 1'b0;
        tick;
        check("rw_ivalid", a_ivalid, 2'b00);
        check("rw_we", a_we, 1'b0);
        check("rw_csel", a_csel, 1'b0);
        check("rw_err", a_err, 1'b0);
        check("rw_wa", a_wa, 5'd0);
        check("rw_a", a_ca, 32'h0);
        check("rw_hold", a_hold, 1'b0);
        check("rw_b_err", b_err, 1'b0);
        rst_n = 1'b1; a_iready = 2'b00;
        tick;
        check("rw_idle_hold", a_hold, 1'b0);
        check("rw_idle_ivalid", a_ivalid, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sr_crypto_seq.md
# sr_crypto_seq

Multi-cycle crypto-instruction sequencer for the schoolRISCV core. It is the parametrised successor of the single-unit crypto stall FSM. When the decoder flags a scalar-crypto instruction, this block stalls the core and latches the operands. It then dispatches the operation to one of `N_UNITS` crypto engines over a valid/ready handshake, waits for the result and writes it back to the register file, with a timeout and illegal-unit fallback.

## Interface
Parameters:
- `DATA_W`, 32, operand/result width
- `MODE_W`, 21, width of the crypto operation code forwarded to engines
- `N_UNITS`, 2, number of crypto engines (≥1)
- `SEL_W`, `$clog2(N_UNITS)` (min 1), width of unit select
- `TIMEOUT`, 64, max cycles from dispatch to result (≥2)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `crypt_instr`  in  1  current instruction is a crypto op (from detector)
- `unit_sel`  in  SEL_W  target engine index
- `cryptoMode`  in  MODE_W  operation code
- `rs1_data`, `rs2_data`  in  DATA_W  operands from register file
- `rd_addr`  in  5  destination register
- `hold`  out  1  stall PC / suppress normal writeback
- `ctrls_select`  out  1  register-file write port owned by sequencer
- `rfWe`  out  1  write enable
- `rfWa`  out  5  write address
- `rfWd`  out  DATA_W  write data
- `cry_i_valid`  out  N_UNITS  one-hot request to engine
- `cry_i_ready`  in  N_UNITS  engine accepts request
- `cry_mode`  out  MODE_W  latched mode, common to all engines
- `cry_a`, `cry_b`  out  DATA_W  latched operands, common
- `cry_o_valid`  in  N_UNITS  engine result valid (one-cycle pulse)
- `cry_o_data`  in  N_UNITS*DATA_W  packed results, unit k at `[k*DATA_W +: DATA_W]`
- `err`  out  1  sticky: timeout or illegal unit since reset

## Operation
- States: IDLE, ISSUE, WAIT, WB.
- IDLE: if `crypt_instr`, latch `unit_sel`, `cryptoMode`, `rs1_data`, `rs2_data`, `rd_addr`.
  - If `unit_sel < N_UNITS`, go to ISSUE.
  - Otherwise set result to 0, set `err`, and go to WB.
- ISSUE: `cry_i_valid[sel]`=1 and all other bits 0. On `cry_i_ready[sel]`, go to WAIT.
- WAIT: on `cry_o_valid[sel]`, latch `cry_o_data[sel]` and go to WB.
  - `o_valid` from non-selected units is ignored.
  - `o_valid[sel]` arriving while in ISSUE is ignored; engines must not respond before accept.
- Timeout: counter cleared on leaving IDLE and incremented every cycle in ISSUE/WAIT. When it reaches `TIMEOUT-1` without completion:
  - result = 0, `err`=1, go to WB;
  - `cry_i_valid` drops.
- WB: `ctrls_select`=1, `rfWa`=latched rd, `rfWd`=latched result.
  - `rfWe`=1 only if rd≠0.
  - `hold`=0, so the PC advances at the end of this cycle. Next state is IDLE.
  - `crypt_instr` is ignored in WB.
- `hold` = (IDLE & `crypt_instr`) | ISSUE | WAIT. This is combinational, so the detecting cycle is already stalled.
- `err` is cleared only by reset.

## Timing
- Reset (`rst_n`=0 at an edge) produces at the following cycle:
  - state IDLE, counter 0, `err`=0, latched regs 0;
  - `cry_i_valid`=0, `rfWe`=0, `ctrls_select`=0;
  - `hold` follows `crypt_instr`.
- Reset mid-operation abandons the request. `i_valid` drops with no completion and engines must tolerate this.
- Minimum latency (engine ready immediately, result 1 cycle after accept): detect at T0, ISSUE at T1, WAIT at T2, WB at T3. `hold` is high T0–T2, which is 3 stall cycles.
- Illegal unit: T0 detect, T1 WB. `hold` high for 1 cycle.
- Timeout: WB occurs at dispatch + `TIMEOUT`, i.e. ISSUE entered at T1 gives WB at T1+`TIMEOUT`.
- Back-to-back crypto instructions: the next one is detected in the cycle after WB (new PC). There is no bubble beyond that.

## Test plan
- Unit 0, `rs1`=0x11, `rs2`=0x22, rd=5, engine ready at T1, `o_valid` at T2 with 0xDEADBEEF -> `hold` 1 for T0–T2. At T3: `rfWe`=1, `rfWa`=5, `rfWd`=0xDEADBEEF, `ctrls_select`=1. `err`=0.
- Unit 1, ready delayed 4 cycles and result 3 cycles later -> `cry_i_valid`=2'b10 stable until accept. `o_valid[0]` pulses during WAIT are ignored. WB writes the unit 1 data.
- Unit 0 never responds, TIMEOUT=64 -> WB at T65 with `rfWd`=0. `err`=1 and stays 1 afterwards.
- `N_UNITS`=3, `unit_sel`=3 -> WB at T1, data 0, `err`=1, no `cry_i_valid`. Also rd=0 with a legal unit -> `rfWe`=0 in WB.
- Two consecutive crypto instructions -> second detected the cycle after the first's WB. Reset asserted during WAIT -> next cycle IDLE with all outputs 0 and `err` 0.
